sd_block_responder: RTL
=======================

Name: sd_block_responder

Overview:
- Target (responder) end of the sector-request interface formed by sd_lba/sd_rd/sd_wr/sd_ack/sd_buff_*.
- Serves 512-byte blocks from a byte-wide backing memory (SDRAM/RAM-disk port), so a disk or cart image can be served without the HPS.
- Connects in place of hps_io's block-device side. Drives the shared sector buffer port A, which the ZPU/core bridge reads and writes through port B.

Parameters:
- ADDR_W, 24, backing-memory byte address width.
- BLK_BYTES, 512, bytes per block. Fixed at 512; sd_buff_addr is 9 bits.

Ports:
- clk_sys, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- sd_lba, in, 32, block number; sampled when a request is accepted.
- sd_rd, in, 1, read request; level, held by initiator until sd_ack.
- sd_wr, in, 1, write request; level, held until sd_ack.
- sd_ack, out, 1, high for the entire transfer.
- sd_buff_addr, out, 9, sector-buffer byte index.
- sd_buff_dout, out, 8, byte into sector buffer (read transfers).
- sd_buff_wr, out, 1, one-cycle write strobe into sector buffer.
- sd_buff_din, in, 8, sector-buffer byte; valid 1 cycle after sd_buff_addr changes.
- img_size, in, 64, image size in bytes.
- img_readonly, in, 1, discard writes.
- mem_addr, out, ADDR_W, backing byte address.
- mem_rd, out, 1, read request; held until mem_ready.
- mem_wr, out, 1, write request; held until mem_ready.
- mem_din, out, 8, write data to memory.
- mem_dout, in, 8, read data; valid on the mem_ready cycle.
- mem_ready, in, 1, one-cycle completion pulse.
- oor_err, out, 1, one-cycle pulse at end of a transfer that touched any out-of-range byte.

Behaviour:
- Reset values: all outputs 0; state IDLE; byte counter idx=0.
- Reset asserted mid-transfer returns to IDLE the next edge, with sd_ack/mem_rd/mem_wr/sd_buff_wr all 0 and no further memory cycles. An outstanding mem_ready arriving afterwards is ignored.

States:
- IDLE: if sd_rd accept read; else if sd_wr accept write (read wins if both high). On accept: latch lba, set sd_ack=1 next cycle, idx=0, go RD_REQ or WR_ADDR.
- Byte address = {lba,9'b0} + idx, computed in 41 bits.
- In range iff address < img_size AND address < 2^ADDR_W. mem_addr = address[ADDR_W-1:0].

Read path:
- RD_REQ: if in range, assert mem_rd and mem_addr, go RD_WAIT. Else set the sticky oor flag and go RD_PUT with data 0.
- RD_WAIT: on mem_ready, capture mem_dout, drop mem_rd, go RD_PUT.
- RD_PUT: sd_buff_addr=idx, sd_buff_dout=data, sd_buff_wr=1 for exactly one cycle. If idx==511 go DONE, else idx++ and go RD_REQ.

Write path:
- WR_ADDR: sd_buff_addr=idx, go WR_FETCH.
- WR_FETCH: wait 1 cycle for dpram latency; capture sd_buff_din into mem_din.
- Then if in range and !img_readonly go WR_REQ. Else (oor sets the flag; readonly does not) skip to WR_NEXT.
- WR_REQ: assert mem_wr; on mem_ready drop it, go WR_NEXT.
- WR_NEXT: if idx==511 go DONE, else idx++ and go WR_ADDR.

DONE:
- sd_ack=0.
- oor_err pulses 1 cycle if the flag is set; clear the flag.
- Go IDLE. A new request may be accepted the cycle after DONE.
- The initiator detects completion on the sd_ack falling edge.

Other rules:
- sd_lba/img_size changes during a transfer are ignored for lba; img_size is re-evaluated per byte.
- Exactly 512 sd_buff_wr pulses per read; zero sd_buff_wr pulses during writes.
- Requests arriving while not IDLE are not queued. The initiator holds its level request, so it is accepted on return to IDLE.
- mem_rd and mem_wr are never asserted together and never while in IDLE.

Test Plan:
- Read lba=2, img_size=4096, memory byte[a]=a[7:0], mem_ready 3 cycles after request. Required: sd_ack high throughout; 512 sd_buff_wr pulses, addr 0..511, dout = addr[7:0] (base 0x400); sd_ack falls; oor_err stays 0.
- Write lba=1, buffer filled with 0xFF-i, img_readonly=0. Required: 512 mem_wr cycles at 0x200..0x3FF with mem_din = 0xFF-i; sd_buff_wr never pulses.
- Read lba=7, img_size=3700 (partial sector). Required: bytes 0..115 come from memory, bytes 116..511 written as 0x00 without mem_rd; one oor_err pulse at DONE.
- Write with img_readonly=1. Required: sd_ack asserted and released normally; zero mem_wr; oor_err=0.
- sd_rd and sd_wr both high at the same edge. Required: read performed. If sd_wr is still held after DONE, the write is accepted next.
- Reset asserted at idx=100 of a read while mem_rd is pending. Required: next cycle sd_ack=0 and mem_rd=0; a late mem_ready causes no sd_buff_wr; a subsequent read completes normally from idx 0.

Source files
------------

// File: rtl/sd_block_responder_if.sv
// Sector-request bus and backing-memory handshake between the block initiator and its responder.
// The slave modport is the responder; the master modport is the initiator plus the memory.
interface sd_block_responder_if #(
  parameter int unsigned ADDR_W = 24
) ();
  logic [31:0]       sd_lba;
  logic              sd_rd;
  logic              sd_wr;
  logic              sd_ack;
  logic [8:0]        sd_buff_addr;
  logic [7:0]        sd_buff_dout;
  logic              sd_buff_wr;
  logic [7:0]        sd_buff_din;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic              mem_ready;

  modport slave (
    input  sd_lba, sd_rd, sd_wr, sd_buff_din, mem_dout, mem_ready,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, mem_addr, mem_rd, mem_wr, mem_din
  );

  modport master (
    output sd_lba, sd_rd, sd_wr, sd_buff_din, mem_dout, mem_ready,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, mem_addr, mem_rd, mem_wr, mem_din
  );
endinterface

// File: rtl/sd_block_responder.sv
// Serves 512-byte block read/write requests from a byte-wide backing memory, one byte at a time,
// moving data through port A of the shared sector buffer.
module sd_block_responder #(
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned BLK_BYTES = 512
) (
  input  logic                clk_sys,
  input  logic                reset,
  sd_block_responder_if.slave bus,
  input  logic [63:0]         img_size,
  input  logic                img_readonly,
  output logic                oor_err
);

  localparam logic [8:0]  LastIdx  = 9'(BLK_BYTES - 1);
  localparam logic [40:0] MemLimit = 41'(1) << ADDR_W;

  typedef enum logic [3:0] {
    StIdle,
    StRdReq,
    StRdWait,
    StRdPut,
    StWrAddr,
    StWrFetch,
    StWrReq,
    StWrNext,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] lba_q, lba_d;
  logic [8:0]  idx_q, idx_d;
  logic [7:0]  data_q, data_d;
  logic        oor_q, oor_d;

  logic [40:0] byte_addr;
  logic        in_range;

  assign byte_addr = {lba_q, 9'd0} + 41'(idx_q);
  // img_size is deliberately not latched so a resized image takes effect per byte.
  assign in_range  = ({23'd0, byte_addr} < img_size) && (byte_addr < MemLimit);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= StIdle;
      lba_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lba_q   <= lba_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      oor_q   <= oor_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lba_d   = lba_q;
    idx_d   = idx_q;
    data_d  = data_q;
    oor_d   = oor_q;
    unique case (state_q)
      StIdle: begin
        if (bus.sd_rd || bus.sd_wr) begin
          lba_d   = bus.sd_lba;
          idx_d   = '0;
          state_d = bus.sd_rd ? StRdReq : StWrAddr;
        end
      end
      StRdReq: begin
        if (in_range) begin
          state_d = StRdWait;
        end else begin
          oor_d   = 1'b1;
          data_d  = '0;
          state_d = StRdPut;
        end
      end
      StRdWait: begin
        if (bus.mem_ready) begin
          data_d  = bus.mem_dout;
          state_d = StRdPut;
        end
      end
      StRdPut: begin
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 9'd1;
          state_d = StRdReq;
        end
      end
      StWrAddr: state_d = StWrFetch;
      StWrFetch: begin
        // Buffer port has one cycle of read latency after sd_buff_addr moved in StWrAddr.
        data_d = bus.sd_buff_din;
        if (in_range && !img_readonly) begin
          state_d = StWrReq;
        end else begin
          if (!in_range) oor_d = 1'b1;
          state_d = StWrNext;
        end
      end
      StWrReq: begin
        if (bus.mem_ready) state_d = StWrNext;
      end
      StWrNext: begin
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 9'd1;
          state_d = StWrAddr;
        end
      end
      StDone: begin
        oor_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.sd_ack       = !(state_q inside {StIdle, StDone});
  assign bus.sd_buff_addr = idx_q;
  assign bus.sd_buff_dout = data_q;
  assign bus.sd_buff_wr   = (state_q == StRdPut);
  assign bus.mem_addr     = byte_addr[ADDR_W-1:0];
  assign bus.mem_rd       = (state_q == StRdWait);
  assign bus.mem_wr       = (state_q == StWrReq);
  assign bus.mem_din      = data_q;
  assign oor_err          = (state_q == StDone) && oor_q;

endmodule
